// File: rtl/uc_pkg.sv
// Shared types and sizing helpers for the unit-clause queue.
// Literals are signed two's complement; zero is never a legal literal.
package uc_pkg;

  localparam int LIT_W_DEF = 10;

  typedef logic signed [LIT_W_DEF-1:0] lit_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uc_multi_queue_if.sv
// Push/pop handshake bundle for the unit-clause queue.
// master = producers/arbiter side, slave = queue side.
interface uc_multi_queue_if #(
  parameter int LIT_W  = 10,
  parameter int NUM_IN = 2
);
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0][LIT_W-1:0] in_lit;
  logic                         in_ready;
  logic                         out_valid;
  logic [LIT_W-1:0]             out_lit;
  logic                         out_ready;

  modport master (
    output in_valid, in_lit, out_ready,
    input  in_ready, out_valid, out_lit
  );

  modport slave (
    input  in_valid, in_lit, out_ready,
    output in_ready, out_valid, out_lit
  );
endinterface

// File: rtl/uc_lane_compact.sv
// Filters zero lanes, merges same-cycle duplicates, flags x/-x pairs
// and left-packs surviving literals in ascending lane order.
module uc_lane_compact #(
  parameter int LIT_W  = 10,
  parameter int NUM_IN = 2,
  parameter int KW     = 2
) (
  input  logic [NUM_IN-1:0]            valid,
  input  logic [NUM_IN-1:0][LIT_W-1:0] lit,
  output logic [NUM_IN-1:0][LIT_W-1:0] packed_lit,
  output logic [KW-1:0]                k,
  output logic                         conflict_raw,
  output logic                         drop_raw
);

  logic [NUM_IN-1:0] live;
  logic [NUM_IN-1:0] keep;

  always_comb begin
    packed_lit   = '0;
    k            = '0;
    conflict_raw = 1'b0;
    drop_raw     = 1'b0;
    live         = '0;
    keep         = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      live[i]  = valid[i] && (lit[i] != '0);
      drop_raw = drop_raw | (valid[i] && (lit[i] == '0));
    end
    for (int i = 0; i < NUM_IN; i++) begin
      keep[i] = live[i];
      for (int j = 0; j < i; j++) begin
        if (live[j] && lit[j] == lit[i])
          keep[i] = 1'b0;
        // the lit[j] != lit[i] term keeps the most-negative value
        // (its own negation) from looking like a pair
        if (live[j] && live[i] && lit[j] != lit[i] &&
            lit[j] == -lit[i])
          conflict_raw = 1'b1;
      end
      if (keep[i]) begin
        packed_lit[k] = lit[i];
        k = k + KW'(1);
      end
    end
  end

endmodule

// File: rtl/uc_multi_queue.sv
// Multi-lane unit-clause FIFO with FWFT output, count and flush.
// Pointers carry an extra wrap bit to tell full from empty.
module uc_multi_queue
  import uc_pkg::*;
#(
  parameter int LIT_W  = LIT_W_DEF,
  parameter int DEPTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  uc_multi_queue_if.slave         bus,
  output logic [ptr_w(DEPTH)-1:0] count,
  output logic                    empty,
  output logic                    full,
  output logic                    conflict,
  output logic                    drop
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int KW = $clog2(NUM_IN + 1);

  logic [DEPTH-1:0][LIT_W-1:0]  mem;
  logic [PW-1:0]                head;
  logic [PW-1:0]                tail;
  logic [PW-1:0]                space;
  logic [NUM_IN-1:0][LIT_W-1:0] packed_lit;
  logic [KW-1:0]                k;
  logic                         conflict_raw;
  logic                         drop_raw;
  logic                         pop;

  uc_lane_compact #(
    .LIT_W  (LIT_W),
    .NUM_IN (NUM_IN),
    .KW     (KW)
  ) u_compact (
    .valid        (bus.in_valid),
    .lit          (bus.in_lit),
    .packed_lit   (packed_lit),
    .k            (k),
    .conflict_raw (conflict_raw),
    .drop_raw     (drop_raw)
  );

  assign count = tail - head;
  assign empty = head == tail;
  assign full  = (head[AW-1:0] == tail[AW-1:0]) &&
                 (head[AW] != tail[AW]);
  assign space = PW'(DEPTH) - count;

  // registered occupancy only: a same-cycle pop never opens a slot
  assign bus.in_ready  = space >= PW'(NUM_IN);
  assign bus.out_valid = !empty;
  assign bus.out_lit   = mem[head[AW-1:0]];

  assign pop = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem      <= '0;
      head     <= '0;
      tail     <= '0;
      conflict <= 1'b0;
      drop     <= 1'b0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      conflict <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (bus.in_ready) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (i < int'(k))
            mem[tail[AW-1:0] + AW'(i)] <= packed_lit[i];
        end
        tail <= tail + PW'(k);
      end
      if (pop)
        head <= head + PW'(1);
      conflict <= bus.in_ready && conflict_raw;
      drop     <= bus.in_ready ? drop_raw : (|bus.in_valid);
    end
  end

endmodule

// File: tb/tb_uc_multi_queue.sv
// Scenario bench for uc_multi_queue with a queue-based scoreboard.
// Inputs change and outputs are sampled on the falling edge.
module tb_uc_multi_queue;
  import uc_pkg::*;

  localparam int DEPTH  = 8;
  localparam int NUM_IN = 2;
  localparam int PW     = ptr_w(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [PW-1:0] count;
  logic          empty;
  logic          full;
  logic          conflict;
  logic          drop;

  uc_multi_queue_if #(.LIT_W(LIT_W_DEF), .NUM_IN(NUM_IN)) bus ();

  uc_multi_queue #(
    .LIT_W  (LIT_W_DEF),
    .DEPTH  (DEPTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .conflict (conflict),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  lit_t q[$];
  int   errors = 0;
  int   checks = 0;

  // one cycle of stimulus; the scoreboard follows the queue behaviour
  task automatic drive(input logic [1:0] v, input lit_t a,
                       input lit_t b, input logic r, input logic f);
    bit rdy;
    rdy = q.size() <= DEPTH - NUM_IN;
    if (f) begin
      q.delete();
    end else begin
      if (r && q.size() > 0)
        void'(q.pop_front());
      if (rdy) begin
        if (v[0] && a != 0)
          q.push_back(a);
        if (v[1] && b != 0 && !(v[0] && a == b))
          q.push_back(b);
      end
    end
    bus.in_valid  = v;
    bus.in_lit[0] = a;
    bus.in_lit[1] = b;
    bus.out_ready = r;
    flush         = f;
    @(negedge clk);
    bus.in_valid  = '0;
    bus.in_lit    = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic test_drain(input string tag);
    lit_t e;
    int   n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q[0];
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_lit !== e) begin
        errors++;
        $display("FAIL %s drain[%0d]: got v=%b lit=%0d want v=1 lit=%0d",
                 tag, i, bus.out_valid, $signed(bus.out_lit), e);
      end
      drive(2'b00, 0, 0, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL %s drained: got empty=%b count=%0d want 1/0",
               tag, empty, count);
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = '0;
    bus.in_lit    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_lit !== '0) begin
      errors++;
      $display("FAIL reset out: got v=%b lit=%0d want 0/0",
               bus.out_valid, bus.out_lit);
    end
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got count=%0d empty=%b full=%b want 0/1/0",
               count, empty, full);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || conflict !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset pulses: got rdy=%b conf=%b drop=%b want 1/0/0",
               bus.in_ready, conflict, drop);
    end
  endtask

  task automatic test_single();
    drive(2'b01, 5, 0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_lit !== 10'd5) begin
      errors++;
      $display("FAIL single latency: got v=%b lit=%0d want 1/5",
               bus.out_valid, $signed(bus.out_lit));
    end
    drive(2'b00, 0, 0, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single pop: got empty=%b v=%b want 1/0",
               empty, bus.out_valid);
    end
  endtask

  task automatic test_order();
    drive(2'b11, 3, -7, 1'b0, 1'b0);
    checks++;
    if (conflict !== 1'b0 || count !== 4'd2) begin
      errors++;
      $display("FAIL order pair: got conf=%b count=%0d want 0/2",
               conflict, count);
    end
    drive(2'b11, 3, 3, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd3 || drop !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL order merge: got count=%0d drop=%b conf=%b want 3/0/0",
               count, drop, conflict);
    end
    drive(2'b11, 0, -2, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd4 || drop !== 1'b1) begin
      errors++;
      $display("FAIL order zero lane: got count=%0d drop=%b want 4/1",
               count, drop);
    end
    test_drain("order");
  endtask

  task automatic test_conflict();
    drive(2'b11, 4, -4, 1'b0, 1'b0);
    checks++;
    if (conflict !== 1'b1 || count !== 4'd2) begin
      errors++;
      $display("FAIL conflict pulse: got conf=%b count=%0d want 1/2",
               conflict, count);
    end
    drive(2'b00, 0, 0, 1'b0, 1'b0);
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL conflict width: got conf=%b want 0", conflict);
    end
    test_drain("conflict");
  endtask

  task automatic test_full();
    lit_t e;
    drive(2'b11, 11, 12, 1'b0, 1'b0);
    drive(2'b11, 13, 14, 1'b0, 1'b0);
    drive(2'b11, 15, 16, 1'b0, 1'b0);
    drive(2'b11, 17, 18, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || bus.in_ready !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("FAIL full flags: got full=%b rdy=%b count=%0d want 1/0/8",
               full, bus.in_ready, count);
    end
    e = q[0];
    checks++;
    if (bus.out_lit !== e) begin
      errors++;
      $display("FAIL full head: got %0d want %0d", $signed(bus.out_lit), e);
    end
    drive(2'b11, 9, 10, 1'b1, 1'b0);
    checks++;
    if (drop !== 1'b1 || count !== 4'd7 || full !== 1'b0) begin
      errors++;
      $display("FAIL full pop+push: got drop=%b count=%0d full=%b want 1/7/0",
               drop, count, full);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready at 7: got %b want 0", bus.in_ready);
    end
    drive(2'b11, 9, 10, 1'b0, 1'b0);
    checks++;
    if (drop !== 1'b1 || count !== 4'd7) begin
      errors++;
      $display("FAIL drop at 7: got drop=%b count=%0d want 1/7", drop, count);
    end
    drive(2'b00, 0, 0, 1'b0, 1'b0);
    checks++;
    if (drop !== 1'b0) begin
      errors++;
      $display("FAIL drop width: got %b want 0", drop);
    end
    test_drain("full");
  endtask

  task automatic test_wrap();
    lit_t base;
    int   n;
    base = 30;
    for (int r = 0; r < 3; r++) begin
      n = (r < 2) ? 4 : 2;
      for (int j = 0; j < n; j++) begin
        drive(2'b11, base, base + 1, 1'b0, 1'b0);
        base = base + 2;
        checks++;
        if (count !== PW'(q.size()) ||
            full !== (q.size() == DEPTH) || empty !== 1'b0) begin
          errors++;
          $display("FAIL wrap r%0d p%0d: got count=%0d full=%b empty=%b want %0d/%b/0",
                   r, j, count, full, empty, q.size(), q.size() == DEPTH);
        end
      end
      test_drain("wrap");
    end
  endtask

  task automatic test_flush();
    drive(2'b11, 21, 22, 1'b0, 1'b0);
    drive(2'b11, 23, 24, 1'b0, 1'b0);
    drive(2'b01, 25, 0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL flush setup: got count=%0d want 5", count);
    end
    drive(2'b11, 1, 2, 1'b0, 1'b1);
    checks++;
    if (count !== '0 || empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush clear: got count=%0d empty=%b v=%b want 0/1/0",
               count, empty, bus.out_valid);
    end
    checks++;
    if (drop !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL flush pulses: got drop=%b conf=%b want 0/0",
               drop, conflict);
    end
    drive(2'b11, 6, -6, 1'b0, 1'b1);
    checks++;
    if (conflict !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL flush conflict: got conf=%b count=%0d want 0/0",
               conflict, count);
    end
    drive(2'b11, 0, 0, 1'b0, 1'b1);
    checks++;
    if (drop !== 1'b0) begin
      errors++;
      $display("FAIL flush drop: got %b want 0", drop);
    end
  endtask

  task automatic test_async_rst();
    drive(2'b11, 8, -8, 1'b0, 1'b0);
    checks++;
    if (conflict !== 1'b1 || count !== 4'd2) begin
      errors++;
      $display("FAIL pre-rst: got conf=%b count=%0d want 1/2",
               conflict, count);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_lit !== '0 ||
        count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL async rst out: got v=%b lit=%0d count=%0d empty=%b",
               bus.out_valid, bus.out_lit, count, empty);
    end
    checks++;
    if (conflict !== 1'b0 || drop !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async rst pulses: got conf=%b drop=%b rdy=%b want 0/0/1",
               conflict, drop, bus.in_ready);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(2'b01, 12, 0, 1'b0, 1'b0);
    checks++;
    if (bus.out_lit !== 10'd12 || count !== 4'd1) begin
      errors++;
      $display("FAIL post-rst push: got lit=%0d count=%0d want 12/1",
               bus.out_lit, count);
    end
    test_drain("post-rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_conflict();
    test_full();
    test_wrap();
    test_flush();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uc_multi_queue.md
# uc_multi_queue

Multi-producer unit-clause FIFO for the lookup stage. It accepts up to NUM_IN signed literals per cycle from parallel process engines, drops duplicate literals within a cycle, and flags complementary pairs (x and -x) as a conflict. Entries are stored in arrival order and presented to the unit-clause arbiter through a first-word-fall-through valid/ready port. It is the parametrised successor to the single-port unit-clause queue, adding multi-lane push, handshakes, occupancy count and flush.

## Interface
- LIT_W, default 10: literal width in bits, signed two's complement; 0 is not a legal literal.
- DEPTH, default 8: number of entries; must be a power of 2 and at least NUM_IN.
- NUM_IN, default 2: number of push lanes.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear; has priority over push and pop.
- in_valid  in  NUM_IN  per-lane push request.
- in_lit  in  NUM_IN×LIT_W  per-lane signed literal.
- in_ready  out  1  all lanes may push this cycle.
- out_valid  out  1  head entry is valid.
- out_lit  out  LIT_W  head literal.
- out_ready  in  1  consumer takes the head entry.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty / full  out  1 each  count==0 / count==DEPTH.
- conflict  out  1  one-cycle pulse when a same-cycle complementary pair is accepted.
- drop  out  1  one-cycle pulse when an in_valid lane is discarded: in_ready low, or lit==0.

## Operation
- Storage: a DEPTH-entry circular buffer with head/tail pointers of $clog2(DEPTH)+1 bits. The MSB is the wrap bit. Empty when the pointers are fully equal; full when the low bits are equal and the MSBs differ.
- in_ready = (DEPTH - count) >= NUM_IN. It is computed from registered count only, so a pop in the same cycle does not raise it.
- Push when in_ready:
  - Valid lanes with lit≠0 are compacted in ascending lane order.
  - A lane whose literal equals that of a lower-index accepted lane is merged (not written, no drop pulse).
  - The k surviving literals are written at tail..tail+k-1 modulo DEPTH, and tail advances by k.
- Lanes with lit==0, and all valid lanes while in_ready is low, are discarded and pulse drop.
- conflict pulses the cycle after acceptance if any two accepted lanes hold x and -x. Both literals are still enqueued; the arbiter decides what to do.
- Pop: when out_valid && out_ready, head advances by 1. out_ready while empty has no effect.
- Simultaneous push and pop in one cycle: both take effect, and count_next = count + k - pop.
- flush: head = tail = 0, count = 0. Same-cycle pushes are discarded without a drop pulse. conflict and drop are forced to 0 the next cycle.
- Duplicates already stored in the queue are not detected; merging applies only within a single cycle.

## Timing
- Reset values: out_valid 0, out_lit 0, count 0, empty 1, full 0, in_ready 1, conflict 0, drop 0. Storage contents are cleared to 0.
- Push-to-output latency is 1 cycle: a literal pushed at edge n appears on out_lit after edge n if the queue was empty.
- out_lit is driven combinationally from the head entry (FWFT). It is stable while out_valid is high and out_ready is low.
- conflict and drop are registered and last exactly one cycle per event.
- Pointer wrap: after DEPTH cumulative pushes, tail low bits return to 0 and the MSB toggles, with no gap in service.
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.
- Full with a pop in the same cycle: in_ready is still low that cycle, and pushes are dropped.

## Structure
- Package uc_pkg: lit_t (logic signed [LIT_W-1:0]), the LIT_W default, and a ptr width function.
- Sub-module uc_lane_compact (combinational):
  - zero filtering, in-cycle duplicate merge, complementary-pair detection, and left-packing of lanes;
  - outputs: packed literals, k, conflict_raw, drop_raw.
- The top level holds the buffer, pointers, count and registered pulses.

## Test plan
- Reset, then single-lane push of 5 followed by out_ready=1 → out_valid rises 1 cycle after the push, out_lit=5; empty returns to 1 after the pop.
- Push lanes {3,-7} in one cycle, then {3,3} → queue order 3,-7,3; count=3; no conflict.
- Push lanes {4,-4} → both enqueued, conflict=1 for exactly 1 cycle, count=2.
- Fill to DEPTH-1 with DEPTH=8 and NUM_IN=2 → in_ready=0; a push of {9,10} pulses drop, and count stays 7.
- Run 20 pushes interleaved with pops → FIFO order preserved across two pointer wraps, and full/empty flags correct at each boundary.
- With count=5, assert flush together with push {1,2} → count=0 and empty=1 next cycle; drop and conflict stay 0. Async rst mid-stream → outputs reset with no clock edge.
